// File: rtl/umem_arbiter_pkg.sv
// rtl/umem_arbiter_pkg.sv - shared encodings for the unified-memory arbiter
// Response states, owner codes and starvation counter width.
package umem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_IRESP = 2'd1,
    S_DRESP = 2'd2
  } state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int STARVE_W = 4;

  function automatic logic [29:0] byte_to_word(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

endpackage

// File: rtl/umem_arbiter_if.sv
// rtl/umem_arbiter_if.sv - core fetch/data ports plus SRAM side of the arbiter
// slave = arbiter view, master = core + SRAM view.
interface umem_arbiter_if #(
  parameter int AWIDTH = 12
);

  logic              I_REQ;
  logic [31:0]       I_ADDR;
  logic              I_GNT;
  logic              I_RVALID;
  logic [31:0]       I_RDATA;

  logic              D_REQ;
  logic              D_WE;
  logic [3:0]        D_BE;
  logic [31:0]       D_ADDR;
  logic [31:0]       D_WDATA;
  logic              D_GNT;
  logic              D_RVALID;
  logic [31:0]       D_RDATA;

  logic              M_CSN;
  logic              M_WEN;
  logic [3:0]        M_BE;
  logic [AWIDTH-1:0] M_ADDR;
  logic [31:0]       M_DI;
  logic [31:0]       M_DOUT;

  modport slave (
    input  I_REQ, I_ADDR, D_REQ, D_WE, D_BE, D_ADDR, D_WDATA, M_DOUT,
    output I_GNT, I_RVALID, I_RDATA, D_GNT, D_RVALID, D_RDATA,
    output M_CSN, M_WEN, M_BE, M_ADDR, M_DI
  );

  modport master (
    output I_REQ, I_ADDR, D_REQ, D_WE, D_BE, D_ADDR, D_WDATA, M_DOUT,
    input  I_GNT, I_RVALID, I_RDATA, D_GNT, D_RVALID, D_RDATA,
    input  M_CSN, M_WEN, M_BE, M_ADDR, M_DI
  );

endinterface

// File: rtl/umem_arbiter_starve_cnt.sv
// rtl/umem_arbiter_starve_cnt.sv - saturating count of fetch lost-contention cycles
// max_o tells the arbiter that fetch must win the next contention.
module umem_starve_cnt
  import umem_arb_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic max_o
);

  localparam logic [STARVE_W-1:0] MAX_C = STARVE_W'(MAX);

  logic [STARVE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign max_o = (cnt_q == MAX_C);

endmodule

// File: rtl/umem_arbiter.sv
// rtl/umem_arbiter.sv - fetch/data sharing of one single-port SRAM, one read in flight
// Optional round-robin contention policy: UMEM_ARB_RR_EN.
module umem_arbiter
  import umem_arb_pkg::*;
#(
  parameter int AWIDTH     = 12,
  parameter int STARVE_MAX = 4
) (
  input logic           CLK,
  input logic           RST,
  umem_arbiter_if.slave bus
);

  logic   i_gnt, d_gnt, both_req, starve_max;
  state_e state_q, state_d;

  assign both_req = bus.I_REQ & bus.D_REQ;

`ifdef UMEM_ARB_RR_EN
  logic rr_last_q, rr_last_d;
`endif

  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!RST) begin
      if (bus.I_REQ && !bus.D_REQ) begin
        i_gnt = 1'b1;
      end else if (bus.D_REQ && !bus.I_REQ) begin
        d_gnt = 1'b1;
      end else if (both_req) begin
        // Starvation guard outranks whichever contention policy is built in.
        if (starve_max) begin
          i_gnt = 1'b1;
`ifdef UMEM_ARB_RR_EN
        end else if (rr_last_q == OWN_D) begin
          i_gnt = 1'b1;
        end else begin
          d_gnt = 1'b1;
`else
        end else begin
          d_gnt = 1'b1;
`endif
        end
      end
    end
  end

  umem_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk_i (CLK),
    .rst_i (RST),
    .inc_i (bus.I_REQ & d_gnt),
    .clr_i (i_gnt | ~bus.I_REQ),
    .max_o (starve_max)
  );

  logic [29:0] i_word, d_word;
  assign i_word = byte_to_word(bus.I_ADDR);
  assign d_word = byte_to_word(bus.D_ADDR);

  always_comb begin
    bus.M_CSN  = 1'b1;
    bus.M_WEN  = 1'b1;
    bus.M_BE   = 4'hF;
    bus.M_ADDR = '0;
    bus.M_DI   = '0;
    if (i_gnt) begin
      bus.M_CSN  = 1'b0;
      bus.M_ADDR = i_word[AWIDTH-1:0];
    end else if (d_gnt) begin
      bus.M_CSN  = 1'b0;
      bus.M_ADDR = d_word[AWIDTH-1:0];
      if (bus.D_WE) begin
        bus.M_WEN = 1'b0;
        bus.M_BE  = bus.D_BE;
        bus.M_DI  = bus.D_WDATA;
      end
    end
  end

  always_comb begin
    state_d = S_IDLE;
    if (i_gnt) begin
      state_d = S_IRESP;
    end else if (d_gnt && !bus.D_WE) begin
      state_d = S_DRESP;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef UMEM_ARB_RR_EN
  always_comb begin
    rr_last_d = rr_last_q;
    if (both_req && (i_gnt || d_gnt)) begin
      rr_last_d = i_gnt ? OWN_I : OWN_D;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_last_q <= OWN_D;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end
`endif

  // Gating with RST drops a response whose grant preceded a reset.
  assign bus.I_GNT    = i_gnt;
  assign bus.D_GNT    = d_gnt;
  assign bus.I_RVALID = (state_q == S_IRESP) & ~RST;
  assign bus.D_RVALID = (state_q == S_DRESP) & ~RST;
  assign bus.I_RDATA  = bus.M_DOUT;
  assign bus.D_RDATA  = bus.M_DOUT;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_word[29:AWIDTH], d_word[29:AWIDTH],
                              bus.I_ADDR[1:0], bus.D_ADDR[1:0]};

endmodule

// File: tb/tb_umem_arbiter.sv
// tb/tb_umem_arbiter.sv - randomized self-checking bench for umem_arbiter
// Reference model works on request/grant rules and a word-array image of memory.
module tb_umem_arbiter;
  import umem_arb_pkg::*;

  localparam int AW = 12;
  localparam int SMAX = 4;
  localparam int NW = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  umem_arbiter_if #(.AWIDTH(AW)) bus ();

  umem_arbiter #(.AWIDTH(AW), .STARVE_MAX(SMAX)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] sram [NW];
  logic [31:0] ref_mem [NW];

  always @(posedge clk) begin
    if (!bus.M_CSN) begin
      if (!bus.M_WEN) begin
        for (int b = 0; b < 4; b++)
          if (!bus.M_BE[b]) sram[bus.M_ADDR][8*b +: 8] <= bus.M_DI[8*b +: 8];
      end else begin
        bus.M_DOUT <= sram[bus.M_ADDR];
      end
    end
  end

  int          m_cnt;
  logic        m_rr_last;
  logic        m_iv, m_dv;
  logic [31:0] m_data;

  logic        c_ir, c_dr, c_dwe;
  logic [31:0] c_ia, c_da, c_dw;
  logic [3:0]  c_dbe;

  function automatic int wa(input logic [31:0] a);
    return int'((a >> 2) % NW);
  endfunction

  function automatic logic [1:0] exp_gnt(input logic ir, input logic dr);
    if (!ir && !dr) return 2'b00;
    if (ir && !dr) return 2'b10;
    if (dr && !ir) return 2'b01;
    if (m_cnt == SMAX) return 2'b10;
`ifdef UMEM_ARB_RR_EN
    return m_rr_last ? 2'b10 : 2'b01;
`else
    return 2'b01;
`endif
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_rr_last = 1'b1;
    m_iv = 1'b0;
    m_dv = 1'b0;
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                       input logic [3:0] dbe, input logic [31:0] da, input logic [31:0] dw);
    c_ir = ir; c_ia = ia; c_dr = dr; c_dwe = dwe; c_dbe = dbe; c_da = da; c_dw = dw;
    bus.I_REQ = ir; bus.I_ADDR = ia; bus.D_REQ = dr; bus.D_WE = dwe;
    bus.D_BE = dbe; bus.D_ADDR = da; bus.D_WDATA = dw;
    #3;
  endtask

  task automatic advance();
    logic [1:0] g;
    if (rst) begin
      model_reset();
    end else begin
      g = exp_gnt(c_ir, c_dr);
      if (g[1] || !c_ir) m_cnt = 0;
      else if (g[0] && m_cnt < SMAX) m_cnt++;
      if (c_ir && c_dr) m_rr_last = g[0];
      m_iv = g[1];
      m_dv = g[0] && !c_dwe;
      if (g[1]) m_data = ref_mem[wa(c_ia)];
      if (g[0] && !c_dwe) m_data = ref_mem[wa(c_da)];
      if (g[0] && c_dwe)
        for (int b = 0; b < 4; b++)
          if (!c_dbe[b]) ref_mem[wa(c_da)][8*b +: 8] = c_dw[8*b +: 8];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [1:0] g;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
      checks++; if (bus.I_GNT !== 1'b0) begin failures++; $display("FAIL rst_ignt got=%b exp=0", bus.I_GNT); end
      checks++; if (bus.D_GNT !== 1'b0) begin failures++; $display("FAIL rst_dgnt got=%b exp=0", bus.D_GNT); end
      checks++; if (bus.M_CSN !== 1'b1) begin failures++; $display("FAIL rst_csn got=%b exp=1", bus.M_CSN); end
      checks++; if ({bus.M_WEN, bus.M_BE, bus.M_ADDR, bus.M_DI} !== {1'b1, 4'hF, 12'h0, 32'h0}) begin
        failures++; $display("FAIL rst_mbus got=%b/%h/%h/%h exp=1/f/000/00000000", bus.M_WEN, bus.M_BE, bus.M_ADDR, bus.M_DI); end
      checks++; if ({bus.I_RVALID, bus.D_RVALID} !== 2'b00) begin
        failures++; $display("FAIL rst_rvalid got=%b%b exp=00", bus.I_RVALID, bus.D_RVALID); end
      advance();
    end
    rst = 1'b0;
    drive(1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
    g = exp_gnt(1'b1, 1'b1);
    checks++; if ({bus.I_GNT, bus.D_GNT} !== g) begin
      failures++; $display("FAIL rel_gnt got=%b%b exp=%b", bus.I_GNT, bus.D_GNT, g); end
`ifndef UMEM_ARB_RR_EN
    checks++; if (bus.D_GNT !== 1'b1) begin failures++; $display("FAIL rel_dfirst got=%b exp=1", bus.D_GNT); end
`endif
    advance();
  endtask

  task automatic test_lone_fetch();
    drive(1'b1, 32'h0000_0010, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
    checks++; if (bus.I_GNT !== 1'b1) begin failures++; $display("FAIL lf_ignt got=%b exp=1", bus.I_GNT); end
    checks++; if (bus.M_ADDR !== 12'd4) begin failures++; $display("FAIL lf_maddr got=%h exp=004", bus.M_ADDR); end
    checks++; if ({bus.M_CSN, bus.M_WEN} !== 2'b01) begin
      failures++; $display("FAIL lf_csn_wen got=%b%b exp=01", bus.M_CSN, bus.M_WEN); end
    advance();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
    checks++; if (bus.I_RVALID !== 1'b1) begin failures++; $display("FAIL lf_rvalid got=%b exp=1", bus.I_RVALID); end
    checks++; if (bus.I_RDATA !== 32'hDEADBEEF) begin failures++; $display("FAIL lf_rdata got=%h exp=deadbeef", bus.I_RDATA); end
    advance();
  endtask

  task automatic test_write_read();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b1100, 32'h0000_0020, 32'h11223344);
    checks++; if (bus.D_GNT !== 1'b1) begin failures++; $display("FAIL wr_dgnt got=%b exp=1", bus.D_GNT); end
    checks++; if ({bus.M_CSN, bus.M_WEN, bus.M_BE, bus.M_ADDR, bus.M_DI} !== {1'b0, 1'b0, 4'b1100, 12'd8, 32'h11223344}) begin
      failures++; $display("FAIL wr_mbus got=%b%b/%b/%h/%h exp=00/1100/008/11223344", bus.M_CSN, bus.M_WEN, bus.M_BE, bus.M_ADDR, bus.M_DI); end
    advance();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
    checks++; if (bus.D_RVALID !== 1'b0) begin failures++; $display("FAIL wr_norvalid got=%b exp=0", bus.D_RVALID); end
    checks++; if ({bus.D_GNT, bus.M_WEN, bus.M_BE} !== {1'b1, 1'b1, 4'hF}) begin
      failures++; $display("FAIL rd_mbus got=%b%b%h exp=11f", bus.D_GNT, bus.M_WEN, bus.M_BE); end
    advance();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
    checks++; if (bus.D_RVALID !== 1'b1) begin failures++; $display("FAIL rd_rvalid got=%b exp=1", bus.D_RVALID); end
    checks++; if (bus.D_RDATA !== 32'h00003344) begin failures++; $display("FAIL rd_rdata got=%h exp=00003344", bus.D_RDATA); end
    advance();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h10, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
    checks++; if (bus.I_GNT !== 1'b1) begin failures++; $display("FAIL b2b_ignt got=%b exp=1", bus.I_GNT); end
    advance();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
    checks++; if ({bus.I_RVALID, bus.D_GNT, bus.I_GNT} !== 3'b110) begin
      failures++; $display("FAIL b2b_n1 got=%b%b%b exp=110", bus.I_RVALID, bus.D_GNT, bus.I_GNT); end
    checks++; if (bus.I_RDATA !== 32'hDEADBEEF) begin failures++; $display("FAIL b2b_irdata got=%h exp=deadbeef", bus.I_RDATA); end
    advance();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
    checks++; if ({bus.D_RVALID, bus.I_RVALID} !== 2'b10) begin
      failures++; $display("FAIL b2b_n2 got=%b%b exp=10", bus.D_RVALID, bus.I_RVALID); end
    checks++; if (bus.D_RDATA !== 32'h00003344) begin failures++; $display("FAIL b2b_drdata got=%h exp=00003344", bus.D_RDATA); end
    advance();
  endtask

  task automatic test_starvation();
    logic [1:0] g;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
    advance();
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
      g = exp_gnt(1'b1, 1'b1);
      checks++; if ({bus.I_GNT, bus.D_GNT} !== g) begin
        failures++; $display("FAIL starve_gnt k=%0d got=%b%b exp=%b", k, bus.I_GNT, bus.D_GNT, g); end
`ifndef UMEM_ARB_RR_EN
      checks++; if (bus.I_GNT !== ((k % 5) == 4)) begin
        failures++; $display("FAIL starve_seq k=%0d got=%b exp=%b", k, bus.I_GNT, (k % 5) == 4); end
`endif
      if (k > 0) begin
        checks++; if ({bus.I_RVALID, bus.D_RVALID} !== {m_iv, m_dv}) begin
          failures++; $display("FAIL starve_rv k=%0d got=%b%b exp=%b%b", k, bus.I_RVALID, bus.D_RVALID, m_iv, m_dv); end
        checks++; if (bus.D_RDATA !== m_data) begin
          failures++; $display("FAIL starve_rdata k=%0d got=%h exp=%h", k, bus.D_RDATA, m_data); end
      end
      advance();
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
    checks++; if (bus.D_GNT !== 1'b1) begin failures++; $display("FAIL mr_dgnt got=%b exp=1", bus.D_GNT); end
    advance();
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
    checks++; if ({bus.D_RVALID, bus.I_RVALID} !== 2'b00) begin
      failures++; $display("FAIL mr_rvalid got=%b%b exp=00", bus.D_RVALID, bus.I_RVALID); end
    advance();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
    checks++; if (bus.D_RVALID !== 1'b0) begin failures++; $display("FAIL mr_after got=%b exp=0", bus.D_RVALID); end
    checks++; if (dut.state_q !== S_IDLE) begin failures++; $display("FAIL mr_state got=%0d exp=%0d", dut.state_q, S_IDLE); end
    advance();
  endtask

  task automatic test_random();
    logic        pi, pd, pwe;
    logic [31:0] pia, pda, pdw;
    logic [3:0]  pbe;
    logic [1:0]  g;
    pi = 1'b0; pd = 1'b0; pwe = 1'b0; pia = '0; pda = '0; pdw = '0; pbe = 4'hF;
    for (int k = 0; k < 400; k++) begin
      if (!pi && ($urandom_range(0, 2) != 0)) begin
        pi = 1'b1;
        pia = {$urandom_range(0, 262143), 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))} ;
      end
      if (!pd && ($urandom_range(0, 2) != 0)) begin
        pd = 1'b1; pwe = 1'($urandom_range(0, 1)); pbe = 4'($urandom_range(0, 15)); pdw = $urandom;
        pda = {$urandom_range(0, 262143), 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
      end
      drive(pi, pia, pd, pwe, pbe, pda, pdw);
      g = exp_gnt(pi, pd);
      checks++; if ({bus.I_GNT, bus.D_GNT} !== g) begin
        failures++; $display("FAIL rnd_gnt k=%0d got=%b%b exp=%b", k, bus.I_GNT, bus.D_GNT, g); end
      checks++; if (bus.M_CSN !== (g == 2'b00)) begin
        failures++; $display("FAIL rnd_csn k=%0d got=%b exp=%b", k, bus.M_CSN, g == 2'b00); end
      if (g != 2'b00) begin
        checks++; if (int'(bus.M_ADDR) !== wa(g[1] ? pia : pda)) begin
          failures++; $display("FAIL rnd_maddr k=%0d got=%0d exp=%0d", k, bus.M_ADDR, wa(g[1] ? pia : pda)); end
        checks++; if (bus.M_WEN !== !(g[0] && pwe)) begin
          failures++; $display("FAIL rnd_wen k=%0d got=%b exp=%b", k, bus.M_WEN, !(g[0] && pwe)); end
      end
      checks++; if ({bus.I_RVALID, bus.D_RVALID} !== {m_iv, m_dv}) begin
        failures++; $display("FAIL rnd_rvalid k=%0d got=%b%b exp=%b%b", k, bus.I_RVALID, bus.D_RVALID, m_iv, m_dv); end
      if (m_iv || m_dv) begin
        checks++; if ((m_iv ? bus.I_RDATA : bus.D_RDATA) !== m_data) begin
          failures++; $display("FAIL rnd_rdata k=%0d got=%h exp=%h", k, m_iv ? bus.I_RDATA : bus.D_RDATA, m_data); end
      end
      advance();
      if (g[1]) pi = 1'b0;
      if (g[0]) pd = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < NW; i++) begin
      sram[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    sram[4] = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;
    bus.M_DOUT = 32'h0;
    model_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    test_reset();
    test_lone_fetch();
    test_write_read();
    test_back_to_back();
    test_starvation();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
